uart_boot_loader: RTL and testbench

//  Streams a program image received as bytes from the UART RX into the instruction SRAM write port, replacing

---
 rtl/uart_boot_loader_pkg.sv | 16 +
 rtl/uart_boot_loader_word_assembler.sv | 36 +++
 rtl/uart_boot_loader.sv | 126 ++++++++++++
 tb/tb_uart_boot_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// uart_boot_loader_pkg: boot loader state codes, frame constants and length check
package uart_boot_loader_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;
  localparam logic [7:0] MAGIC_DEF = 8'hA5;
  localparam int LEN_W = 16;
  localparam int WORD_W = 32;
  function automatic logic len_ok(input logic [LEN_W-1:0] n, input int aw);
    return {16'd0, n} <= (32'd1 << aw);
  endfunction
endpackage

// File: rtl/uart_boot_loader_word_assembler.sv
// boot_word_assembler: packs payload bytes LSB-first into words and keeps the running XOR
module boot_word_assembler
  import uart_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        data_i,
  output logic              ready_o,
  output logic [WORD_W-1:0] word_o,
  output logic [7:0]        csum_o
);
  logic [1:0]  lane_q, lane_d;
  logic [23:0] sh_q, sh_d;
  logic [7:0]  x_q, x_d;
  always_comb begin
    lane_d  = clr ? 2'd0 : en ? lane_q + 2'd1 : lane_q;
    sh_d    = clr ? 24'd0 : en ? {data_i, sh_q[23:8]} : sh_q;
    x_d     = clr ? 8'd0 : en ? x_q ^ data_i : x_q;
    ready_o = en && lane_q == 2'd3;
    word_o  = {data_i, sh_q};
    csum_o  = x_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      sh_q   <= '0;
      x_q    <= '0;
    end else begin
      lane_q <= lane_d;
      sh_q   <= sh_d;
      x_q    <= x_d;
    end
  end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a checksummed UART image into isram and holds the core in reset until done
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int         ADDR_W      = 12,
  parameter int         TIMEOUT_CYC = 200000,
  parameter logic [7:0] MAGIC       = MAGIC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_sel_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_err_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [2:0]        state_q, state_d;
  logic              first_q, first_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d, n_rx;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_rst_q, core_rst_d, done_q, done_d, err_q, err_d;
  logic              active, rx_ok, clr, en, timeout, ready;
  logic [31:0]       word;
  logic [7:0]        csum;
  boot_word_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (en),
    .data_i  (rx_data_i),
    .ready_o (ready),
    .word_o  (word),
    .csum_o  (csum)
  );
  always_comb begin
    active      = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
    rx_ok       = rx_valid_i && !rx_err_i;
    clr         = state_q == S_IDLE && rx_valid_i && rx_data_i == MAGIC;
    en          = state_q == S_DATA && rx_ok;
    timeout     = active && !rx_valid_i && tmo_q == TW'(TIMEOUT_CYC - 1);
    n_rx        = {rx_data_i, len_q[7:0]};
    state_d     = state_q;
    first_d     = 1'b0;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (first_q && !boot_sel_i) state_d = S_DONE;
        else if (clr) begin
          state_d = S_LEN0;
          cnt_d   = '0;
        end
      end
      S_LEN0: if (rx_ok) begin
        len_d[7:0] = rx_data_i;
        state_d    = S_LEN1;
      end
      S_LEN1: if (rx_ok) begin
        len_d   = n_rx;
        state_d = n_rx == '0 ? S_CSUM : !len_ok(n_rx, ADDR_W) ? S_ERR : S_DATA;
      end
      S_DATA: if (ready) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = cnt_q[ADDR_W-1:0];
        mem_wdata_d = word;
        cnt_d       = cnt_q + 1'b1;
        state_d     = cnt_q == len_q - 1'b1 ? S_CSUM : S_DATA;
      end
      S_CSUM: if (rx_ok) state_d = rx_data_i == csum ? S_DONE : S_ERR;
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Line errors and stalls abort any in-progress frame
    if (active && ((rx_valid_i && rx_err_i) || timeout)) state_d = S_ERR;
    tmo_d      = (!active || rx_valid_i || state_d != state_q) ? '0 : tmo_q + TW'(1);
    done_d     = state_d == S_DONE;
    core_rst_d = state_q != S_DONE;
    err_d      = state_d == S_ERR || (err_q && !clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      first_q     <= 1'b1;
      len_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign core_rst_o  = core_rst_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed and random frames checked against a byte-level frame model
module tb_uart_boot_loader;
  localparam int AW = 12;
  localparam int TMO = 64;
  logic clk = 1'b0, rst = 1'b1, boot_sel = 1'b1, rx_valid = 1'b0, rx_err = 1'b0;
  logic [7:0] rx_data = '0;
  logic mem_we, core_rst, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  int total = 0, bad = 0;
  logic [43:0] wq[$];
  logic [31:0] pay[$];
  logic [7:0] fb[$];
  uart_boot_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .boot_sel_i(boot_sel), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_err_i(rx_err), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .core_rst_o(core_rst), .done_o(done), .err_o(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) wq.push_back({mem_addr, mem_wdata});
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset(input logic bs);
    rst = 1'b1;
    boot_sel = bs;
    rx_valid = 1'b0;
    rx_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    wq.delete();
  endtask
  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_valid = 1'b1;
    rx_data = b;
    rx_err = e;
    tick();
    rx_valid = 1'b0;
    rx_err = 1'b0;
  endtask
  task automatic build(input int n, input bit rnd, input bit bad_cs);
    logic [7:0] x;
    logic [31:0] w;
    x = '0;
    fb.delete();
    if (rnd) begin
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back($urandom);
    end
    fb.push_back(8'hA5);
    fb.push_back(n[7:0]);
    fb.push_back(n[15:8]);
    foreach (pay[i]) begin
      w = pay[i];
      for (int k = 0; k < 4; k++) begin
        fb.push_back(w[8*k +: 8]);
        x ^= w[8*k +: 8];
      end
    end
    fb.push_back(bad_cs ? x ^ 8'h01 : x);
  endtask
  task automatic send(input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      if (i > from) repeat ($urandom_range(gap)) tick();
      send_byte(fb[i], 1'b0);
    end
  endtask
  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wq.size(), pay.size());
    foreach (pay[i]) if (i < wq.size()) begin
      chk({tag, "_addr"}, 32'(wq[i][43:32]), 32'(i));
      chk({tag, "_data"}, wq[i][31:0], pay[i]);
    end
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_core_rst"}, 32'(core_rst), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask
  initial begin
    tick();
    tick();
    check_reset_vals("rst0");
    // skip loader
    do_reset(1'b0);
    tick();
    chk("skip_done", 32'(done), 1);
    chk("skip_core_rst1", 32'(core_rst), 1);
    tick();
    chk("skip_core_rst0", 32'(core_rst), 0);
    repeat (3) tick();
    chk("skip_nwr", wq.size(), 0);
    // known two-word image
    do_reset(1'b1);
    pay.delete();
    pay.push_back(32'h12345678);
    pay.push_back(32'hDEADBEEF);
    build(2, 0, 0);
    send(0, fb.size(), 0);
    chk("img_done", 32'(done), 1);
    chk("img_err", 32'(err), 0);
    chk("img_core_rst_lat", 32'(core_rst), 1);
    tick();
    chk("img_core_rst", 32'(core_rst), 0);
    check_writes("img");
    // bad checksum then recovery
    do_reset(1'b1);
    build(2, 0, 1);
    send(0, fb.size(), 0);
    chk("badcs_err", 32'(err), 1);
    chk("badcs_done", 32'(done), 0);
    check_writes("badcs");
    repeat (3) tick();
    chk("badcs_core_rst", 32'(core_rst), 1);
    chk("badcs_sticky", 32'(err), 1);
    wq.delete();
    build(3, 1, 0);
    send(0, 1, 0);
    chk("magic_clr_err", 32'(err), 0);
    send(1, fb.size(), 1);
    chk("retry_done", 32'(done), 1);
    check_writes("retry");
    // zero length and length bounds
    do_reset(1'b1);
    pay.delete();
    build(0, 0, 0);
    send(0, fb.size(), 0);
    chk("zero_done", 32'(done), 1);
    chk("zero_nwr", wq.size(), 0);
    do_reset(1'b1);
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    chk("len_over_err", 32'(err), 1);
    do_reset(1'b1);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    repeat (5) tick();
    chk("len_max_ok", 32'(err), 0);
    // timeout, rx errors
    do_reset(1'b1);
    send_byte(8'h3C, 1);
    chk("idle_rxerr_ignored", 32'(err), 0);
    build(3, 1, 0);
    send(0, 9, 0);
    repeat (TMO - 1) tick();
    chk("tmo_before", 32'(err), 0);
    tick();
    chk("tmo_at", 32'(err), 1);
    chk("tmo_core_rst", 32'(core_rst), 1);
    tick();
    build(2, 1, 0);
    send(0, 8, 0);
    chk("rxerr_pre", 32'(err), 0);
    send_byte(fb[8], 1);
    chk("rxerr_err", 32'(err), 1);
    tick();
    wq.delete();
    build(2, 1, 0);
    send(0, fb.size(), 2);
    chk("post_err_done", 32'(done), 1);
    check_writes("post_err");
    // reset mid-payload
    do_reset(1'b1);
    build(5, 1, 0);
    send(0, 16, 0);
    chk("mid_nwr", wq.size(), 3);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    tick();
    rst = 1'b0;
    wq.delete();
    build(4, 1, 0);
    send(0, fb.size(), 1);
    chk("midrst_done", 32'(done), 1);
    check_writes("midrst");
    // random frames
    for (int r = 0; r < 6; r++) begin
      int n;
      bit bcs;
      do_reset(1'b1);
      n = $urandom_range(1, 6);
      bcs = 1'($urandom_range(0, 1));
      build(n, 1, bcs);
      send(0, fb.size(), 2);
      chk("rnd_done", 32'(done), 32'(!bcs));
      chk("rnd_err", 32'(err), 32'(bcs));
      check_writes("rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
